// File: rtl/alu_op_sequencer_pkg.sv
// Shared op codes, operand-select encodings and FSM state type for the ALU op sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;

  localparam logic [1:0] SEL_B    = 2'b00;
  localparam logic [1:0] SEL_NB   = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Codes 11x are reserved and answered without touching the unit.
  function automatic logic is_illegal(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response channels of the ALU op sequencer; rsp_mismatch exists only with ALU_SEQ_CHECK_EN.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_illegal;
`ifdef ALU_SEQ_CHECK_EN
  logic             rsp_mismatch;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal, rsp_mismatch
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal, rsp_mismatch
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal
  );
`endif

endinterface

// File: rtl/alu_op_sequencer_flag_calc.sv
// Local model of the unit's adder: expected carry and zero, plus the sum when ALU_SEQ_CHECK_EN is defined.
module alu_flag_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] opnd,
  input  logic             cin,
`ifdef ALU_SEQ_CHECK_EN
  output logic [WIDTH-1:0] sum,
`endif
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] full;

  assign full  = {1'b0, a} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};
  assign carry = full[WIDTH];
  assign zero  = (full[WIDTH-1:0] == '0);

`ifdef ALU_SEQ_CHECK_EN
  assign sum = full[WIDTH-1:0];
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front end for the 8-bit calculation unit: one op in flight, result sampled after LAT clocks.
// Optional result cross-check against the local adder model is enabled by ALU_SEQ_CHECK_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] cu_a,
  output logic [WIDTH-1:0] cu_b,
  output logic [1:0]       cu_select,
  output logic             cu_cin,
  input  logic [WIDTH-1:0] cu_result
);

  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             accept;
  logic             rsp_hs;
  logic [1:0]       map_select;
  logic             map_cin;
  logic [WIDTH-1:0] opnd;
  logic             exp_carry;
  logic             exp_zero;
`ifdef ALU_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_sum;
`endif

  assign accept = bus.req_valid & bus.req_ready;
  assign rsp_hs = (state == RESP) & bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = is_illegal(bus.req_op) ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    if (rsp_hs) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // req_ready is forced low while rst is asserted, even though state already reads IDLE.
  always_comb begin
    bus.req_ready = (state == IDLE) && !rst;
    bus.rsp_valid = (state == RESP);
  end

  always_comb begin
    map_select = SEL_B;
    map_cin    = 1'b0;
    case (bus.req_op)
      OP_ADC:  map_cin = carry_q;
      OP_SUB:  begin map_select = SEL_NB;   map_cin = 1'b1; end
      OP_INC:  begin map_select = SEL_ZERO; map_cin = 1'b1; end
      OP_PASS: begin map_select = SEL_ZERO; map_cin = 1'b0; end
      OP_DEC:  begin map_select = SEL_ONES; map_cin = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    opnd = cu_b;
    case (cu_select)
      SEL_B:    opnd = cu_b;
      SEL_NB:   opnd = ~cu_b;
      SEL_ZERO: opnd = '0;
      default:  opnd = '1;
    endcase
  end

  alu_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
    .a     (cu_a),
    .opnd  (opnd),
    .cin   (cu_cin),
`ifdef ALU_SEQ_CHECK_EN
    .sum   (exp_sum),
`endif
    .carry (exp_carry),
    .zero  (exp_zero)
  );

  // Unit inputs change only on a legal accept; the response is loaded once and held until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      carry_q         <= 1'b0;
      cu_a            <= '0;
      cu_b            <= '0;
      cu_select       <= '0;
      cu_cin          <= 1'b0;
      bus.rsp_result  <= '0;
      bus.rsp_carry   <= 1'b0;
      bus.rsp_zero    <= 1'b0;
      bus.rsp_illegal <= 1'b0;
`ifdef ALU_SEQ_CHECK_EN
      bus.rsp_mismatch <= 1'b0;
`endif
    end else begin
      if (state == IDLE && accept) begin
        if (is_illegal(bus.req_op)) begin
          bus.rsp_result  <= '0;
          bus.rsp_carry   <= 1'b0;
          bus.rsp_zero    <= 1'b0;
          bus.rsp_illegal <= 1'b1;
`ifdef ALU_SEQ_CHECK_EN
          bus.rsp_mismatch <= 1'b0;
`endif
        end else begin
          cu_a      <= bus.req_a;
          cu_b      <= bus.req_b;
          cu_select <= map_select;
          cu_cin    <= map_cin;
          cnt       <= CNT_W'(LAT);
        end
      end
      if (state == WAIT) begin
        if (cnt == '0) begin
          bus.rsp_result  <= cu_result;
          bus.rsp_carry   <= exp_carry;
          bus.rsp_zero    <= exp_zero;
          bus.rsp_illegal <= 1'b0;
`ifdef ALU_SEQ_CHECK_EN
          bus.rsp_mismatch <= (cu_result != exp_sum);
`endif
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if (rsp_hs && !bus.rsp_illegal) carry_q <= bus.rsp_carry;
    end
  end

endmodule
